// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and default word/clock geometry.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_pkg;

    localparam int SPI_WORD_W    = 16;
    localparam int SPI_SCLK_HALF = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        SHIFT    = 3'd2,
        CS_HOLD  = 3'd3,
        GAP      = 3'd4
    } spi_state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: half-period counter, registered SCLK, one-cycle rise/fall enables.
// Latency: SCLK goes high on the edge where load is asserted; toggles every SCLK_HALF cycles while run.
// Backpressure: none; driven purely by the FSM's load/run qualifiers.
// Ports: clk/rst; load (next cycle is the first SHIFT cycle), run (next cycle stays in SHIFT);
//        sclk (registered SPI clock), rise_en/fall_en (high in the cycle whose closing edge moves sclk 0->1 / 1->0).
module spi_sclk_gen #(
    parameter int SCLK_HALF = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic sclk,
    output logic rise_en,
    output logic fall_en
);

    localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          sclk_q, sclk_d;

    always_comb begin
        hcnt_d  = hcnt_q;
        sclk_d  = sclk_q;
        rise_en = 1'b0;
        fall_en = 1'b0;
        if (load) begin
            // First edge of a word is always a rise.
            sclk_d  = 1'b1;
            hcnt_d  = HW'(SCLK_HALF - 1);
            rise_en = 1'b1;
        end else if (run) begin
            if (hcnt_q == '0) begin
                sclk_d  = ~sclk_q;
                hcnt_d  = HW'(SCLK_HALF - 1);
                rise_en = ~sclk_q;
                fall_en = sclk_q;
            end else begin
                hcnt_d = hcnt_q - HW'(1);
            end
        end else begin
            // Outside SHIFT the clock parks low.
            sclk_d = 1'b0;
            hcnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q <= '0;
            sclk_q <= 1'b0;
        end else begin
            hcnt_q <= hcnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk = sclk_q;

endmodule

// File: rtl/spi_sensor_master.sv
// SPI mode-0 frame engine: on start runs num_words back-to-back WORD_W-bit transfers, strobes each rx word.
// Latency: CS_b falls 1 cycle after start; word period 2*SCLK_HALF + 2*WORD_W*SCLK_HALF + CS_GAP cycles.
// Backpressure: none; rx_valid is a fire-and-forget strobe, start while busy is dropped.
// Ports: clk/reset; start, num_words, cmd_word (host control); MISO_from_sensor, MOSI_to_sensor,
//        SCLK_wire, CS_b_wire (sensor pins); sample_CLK_out (word-0 marker); rx_word/rx_valid;
//        word_idx, busy, done (status).
module spi_sensor_master
    import spi_pkg::*;
#(
    parameter int WORD_W    = SPI_WORD_W,
    parameter int SCLK_HALF = SPI_SCLK_HALF,
    parameter int CS_GAP    = 4,
    parameter int CNT_W     = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_words,
    input  logic [WORD_W-1:0] cmd_word,
    input  logic              MISO_from_sensor,
    output logic              MOSI_to_sensor,
    output logic              SCLK_wire,
    output logic              CS_b_wire,
    output logic              sample_CLK_out,
    output logic [WORD_W-1:0] rx_word,
    output logic              rx_valid,
    output logic [CNT_W-1:0]  word_idx,
    output logic              busy,
    output logic              done
);

    localparam int SHIFT_LEN = 2 * WORD_W * SCLK_HALF;
    localparam int CW        = $clog2(SHIFT_LEN + CS_GAP + SCLK_HALF);

    spi_state_t        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]  words_q, words_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] tx_q, tx_d;
    logic [WORD_W-1:0] rx_sh_q, rx_sh_d;
    logic [WORD_W-1:0] rx_word_q, rx_word_d;
    logic              rx_valid_q, rx_valid_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              cs_b_q, cs_b_d;
    logic              mosi_q, mosi_d;
    logic              sample_q, sample_d;

    logic sclk_load, sclk_run, sclk_rise, sclk_fall;

    // SCLK starts on the edge leaving CS_SETUP and keeps running until the last SHIFT cycle.
    assign sclk_load = (state_q == CS_SETUP) && (cnt_q == '0);
    assign sclk_run  = (state_q == SHIFT) && (cnt_q != '0);

    spi_sclk_gen #(
        .SCLK_HALF (SCLK_HALF)
    ) u_sclk_gen (
        .clk     (clk),
        .rst     (reset),
        .load    (sclk_load),
        .run     (sclk_run),
        .sclk    (SCLK_wire),
        .rise_en (sclk_rise),
        .fall_en (sclk_fall)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        words_d    = words_q;
        idx_d      = idx_q;
        tx_d       = tx_q;
        rx_sh_d    = rx_sh_q;
        rx_word_d  = rx_word_q;
        rx_valid_d = 1'b0;
        done_d     = 1'b0;
        busy_d     = busy_q;
        cs_b_d     = cs_b_q;
        mosi_d     = mosi_q;
        sample_d   = sample_q;

        case (state_q)
            IDLE: begin
                if (start && (num_words != '0)) begin
                    state_d  = CS_SETUP;
                    cnt_d    = CW'(SCLK_HALF - 1);
                    words_d  = num_words;
                    idx_d    = '0;
                    tx_d     = cmd_word;
                    mosi_d   = cmd_word[WORD_W-1];
                    cs_b_d   = 1'b0;
                    busy_d   = 1'b1;
                    sample_d = 1'b1;
                end
            end
            CS_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = SHIFT;
                    cnt_d   = CW'(SHIFT_LEN - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    state_d = CS_HOLD;
                    cnt_d   = CW'(SCLK_HALF - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            CS_HOLD: begin
                if (cnt_q == '0) begin
                    // Entering GAP: release CS and publish the completed word.
                    state_d    = GAP;
                    cnt_d      = CW'(CS_GAP - 1);
                    cs_b_d     = 1'b1;
                    mosi_d     = 1'b0;
                    rx_word_d  = rx_sh_q;
                    rx_valid_d = 1'b1;
                    sample_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    if (idx_q == (words_q - CNT_W'(1))) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = CS_SETUP;
                        cnt_d   = CW'(SCLK_HALF - 1);
                        idx_d   = idx_q + CNT_W'(1);
                        tx_d    = cmd_word;
                        mosi_d  = cmd_word[WORD_W-1];
                        cs_b_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Mode 0: sample MISO as SCLK rises, present the next MOSI bit as it falls.
        if (sclk_rise) begin
            rx_sh_d = {rx_sh_q[WORD_W-2:0], MISO_from_sensor};
        end
        if (sclk_fall) begin
            mosi_d = tx_q[WORD_W-2];
            tx_d   = tx_q << 1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            words_q    <= '0;
            idx_q      <= '0;
            tx_q       <= '0;
            rx_sh_q    <= '0;
            rx_word_q  <= '0;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            cs_b_q     <= 1'b1;
            mosi_q     <= 1'b0;
            sample_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            words_q    <= words_d;
            idx_q      <= idx_d;
            tx_q       <= tx_d;
            rx_sh_q    <= rx_sh_d;
            rx_word_q  <= rx_word_d;
            rx_valid_q <= rx_valid_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            cs_b_q     <= cs_b_d;
            mosi_q     <= mosi_d;
            sample_q   <= sample_d;
        end
    end

    assign MOSI_to_sensor = mosi_q;
    assign CS_b_wire      = cs_b_q;
    assign sample_CLK_out = sample_q;
    assign rx_word        = rx_word_q;
    assign rx_valid       = rx_valid_q;
    assign word_idx       = idx_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_spi_sensor_master.sv
// Directed bench for spi_sensor_master: default geometry plus a WORD_W=8/SCLK_HALF=1/CS_GAP=1 instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_sensor_master;

    localparam int P  = 2*2 + 2*16*2 + 4;   // 72
    localparam int P2 = 2*1 + 2*8*1 + 1;    // 19

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- default instance ----------------
    logic        start = 1'b0;
    logic [5:0]  num_words = '0;
    logic [15:0] cmd_word = '0;
    logic        miso = 1'b0;
    logic        mosi, sclk, csb, samp, rx_valid, busy, done;
    logic [15:0] rx_word;
    logic [5:0]  word_idx;

    spi_sensor_master dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .num_words        (num_words),
        .cmd_word         (cmd_word),
        .MISO_from_sensor (miso),
        .MOSI_to_sensor   (mosi),
        .SCLK_wire        (sclk),
        .CS_b_wire        (csb),
        .sample_CLK_out   (samp),
        .rx_word          (rx_word),
        .rx_valid         (rx_valid),
        .word_idx         (word_idx),
        .busy             (busy),
        .done             (done)
    );

    // ---------------- sweep instance ----------------
    logic        start2 = 1'b0;
    logic [5:0]  num2 = '0;
    logic [7:0]  cmd2 = '0;
    logic        miso2 = 1'b0;
    logic        mosi2, sclk2, csb2, samp2, rxv2, busy2, done2;
    logic [7:0]  rxw2;
    logic [5:0]  idx2;

    spi_sensor_master #(
        .WORD_W    (8),
        .SCLK_HALF (1),
        .CS_GAP    (1),
        .CNT_W     (6)
    ) dut2 (
        .clk              (clk),
        .reset            (reset),
        .start            (start2),
        .num_words        (num2),
        .cmd_word         (cmd2),
        .MISO_from_sensor (miso2),
        .MOSI_to_sensor   (mosi2),
        .SCLK_wire        (sclk2),
        .CS_b_wire        (csb2),
        .sample_CLK_out   (samp2),
        .rx_word          (rxw2),
        .rx_valid         (rxv2),
        .word_idx         (idx2),
        .busy             (busy2),
        .done             (done2)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- sensor model + monitor, default instance ----------------
    int unsigned rv_t[$];
    logic [15:0] rv_v[$];
    int unsigned done_t[$];
    int unsigned csf_t[$];
    int unsigned rise_cnt, first_rise, samp_cnt, samp_first, busy_cnt;
    logic [15:0] mosi_cap;
    logic [15:0] sens_sh = '0;
    logic [15:0] sens_resp = '0;
    bit          sens_idx_mode = 1'b0;
    int unsigned sens_cnt = 0;
    logic        sclk_prev = 1'b0;
    logic        csb_prev = 1'b1;

    always @(negedge clk) begin
        if (rx_valid) begin
            rv_t.push_back(cyc);
            rv_v.push_back(rx_word);
        end
        if (done) done_t.push_back(cyc);
        if (busy) busy_cnt++;
        if (samp) begin
            if (samp_cnt == 0) samp_first = cyc;
            samp_cnt++;
        end
        if (sclk && !sclk_prev) begin
            if (rise_cnt == 0) first_rise = cyc;
            rise_cnt++;
            mosi_cap = {mosi_cap[14:0], mosi};
        end
        // Mode-0 slave: first bit on CS fall, next bit after each SCLK fall.
        if (!csb && csb_prev) begin
            csf_t.push_back(cyc);
            sens_sh = sens_idx_mode ? 16'(sens_cnt) : sens_resp;
            sens_cnt++;
            miso = sens_sh[15];
        end else if (!sclk && sclk_prev && !csb) begin
            sens_sh = sens_sh << 1;
            miso = sens_sh[15];
        end
        sclk_prev = sclk;
        csb_prev  = csb;
    end

    // ---------------- sensor model + monitor, sweep instance ----------------
    int unsigned rv2_t[$];
    logic [7:0]  rv2_v[$];
    int unsigned done2_t[$];
    int unsigned rise2_cnt = 0;
    int unsigned first_rise2 = 0;
    logic [7:0]  mosi2_cap = '0;
    logic [7:0]  sens2_sh = '0;
    logic        sclk2_prev = 1'b0;
    logic        csb2_prev = 1'b1;

    always @(negedge clk) begin
        if (rxv2) begin
            rv2_t.push_back(cyc);
            rv2_v.push_back(rxw2);
        end
        if (done2) done2_t.push_back(cyc);
        if (sclk2 && !sclk2_prev) begin
            if (rise2_cnt == 0) first_rise2 = cyc;
            rise2_cnt++;
            mosi2_cap = {mosi2_cap[6:0], mosi2};
        end
        if (!csb2 && csb2_prev) begin
            sens2_sh = 8'h5A;
            miso2 = sens2_sh[7];
        end else if (!sclk2 && sclk2_prev && !csb2) begin
            sens2_sh = sens2_sh << 1;
            miso2 = sens2_sh[7];
        end
        sclk2_prev = sclk2;
        csb2_prev  = csb2;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rv_t.delete();
        rv_v.delete();
        done_t.delete();
        csf_t.delete();
        rise_cnt = 0;
        first_rise = 0;
        samp_cnt = 0;
        samp_first = 0;
        busy_cnt = 0;
        mosi_cap = '0;
    endtask

    task automatic pulse_start(input logic [5:0] n, input logic [15:0] c, output int unsigned t);
        num_words = n;
        cmd_word  = c;
        start     = 1'b1;
        t         = cyc;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] qt(input int unsigned q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int unsigned t0, t1, tx;
        int bad;

        // Asynchronous reset, checked before any clock edge.
        #2 reset = 1'b1;
        #2;
        check_eq("rst_csb",   32'(csb), 32'd1);
        check_eq("rst_sclk",  32'(sclk), 32'd0);
        check_eq("rst_mosi",  32'(mosi), 32'd0);
        check_eq("rst_busy",  32'(busy), 32'd0);
        check_eq("rst_done",  32'(done), 32'd0);
        check_eq("rst_rxv",   32'(rx_valid), 32'd0);
        check_eq("rst_rxw",   32'(rx_word), 32'd0);
        check_eq("rst_idx",   32'(word_idx), 32'd0);
        check_eq("rst_samp",  32'(samp), 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        tick();

        // ---- single word ----
        sens_idx_mode = 1'b0;
        sens_resp = 16'h1234;
        clear_mon();
        pulse_start(6'd1, 16'hA5C3, t0);
        check_eq("sw_busy_t1", 32'(busy), 32'd1);
        check_eq("sw_csb_t1",  32'(csb), 32'd0);
        check_eq("sw_samp_t1", 32'(samp), 32'd1);
        wait_done("sw", 200);
        tick();
        tick();
        check_eq("sw_rv_cnt",   32'(rv_v.size()), 32'd1);
        check_eq("sw_rx_word",  (rv_v.size() > 0) ? 32'(rv_v[0]) : 32'hFFFF_FFFF, 32'h1234);
        check_eq("sw_rv_time",  qt(rv_t, 0) - t0, 32'd69);
        check_eq("sw_done_t",   qt(done_t, 0) - t0, 32'd73);
        check_eq("sw_rises",    rise_cnt, 32'd16);
        check_eq("sw_rise0_t",  first_rise - t0, 32'd3);
        check_eq("sw_mosi",     32'(mosi_cap), 32'hA5C3);
        check_eq("sw_samp_cnt", samp_cnt, 32'(P - 4));
        check_eq("sw_busy_end", 32'(busy), 32'd0);

        // ---- frame of 31, then back-to-back 5 with a start pulsed mid-frame ----
        sens_idx_mode = 1'b1;
        sens_cnt = 0;
        clear_mon();
        pulse_start(6'd31, 16'h3C5A, t0);
        wait_done("f31", 2400);
        t1 = cyc;
        pulse_start(6'd5, 16'h0001, tx);
        repeat (99) tick();
        check_eq("b2b_idx_mid", 32'(word_idx), 32'd1);
        pulse_start(6'd3, 16'hFFFF, tx);
        wait_done("b2b", 600);
        tick();
        tick();
        check_eq("f31_rv_cnt", 32'(rv_v.size()), 32'd36);
        bad = 0;
        for (int i = 0; i < rv_v.size(); i++) if (rv_v[i] != 16'(i)) bad++;
        check_eq("f31_values", 32'(bad), 32'd0);
        bad = 0;
        for (int i = 1; i < rv_t.size(); i++)
            if (i != 31 && (rv_t[i] - rv_t[i-1]) != P) bad++;
        check_eq("f31_spacing", 32'(bad), 32'd0);
        check_eq("f31_rv0_t",   qt(rv_t, 0) - t0, 32'd69);
        check_eq("f31_done_t",  qt(done_t, 0) - t0, 32'd2233);
        check_eq("b2b_start_t", t1 - t0, 32'd2233);
        check_eq("b2b_csf_t",   qt(csf_t, 31) - t1, 32'd1);
        check_eq("b2b_rv0_t",   qt(rv_t, 31) - t1, 32'd69);
        check_eq("b2b_done_t",  qt(done_t, 1) - t1, 32'(1 + 5*P));
        check_eq("b2b_done_n",  32'(done_t.size()), 32'd2);
        check_eq("f_csf_n",     32'(csf_t.size()), 32'd36);
        check_eq("f_samp_cnt",  samp_cnt, 32'(2*(P - 4)));
        check_eq("f_samp0_t",   samp_first - t0, 32'd1);

        // ---- start with num_words = 0 is ignored ----
        clear_mon();
        pulse_start(6'd0, 16'h1111, tx);
        repeat (20) tick();
        check_eq("z_busy_cyc", busy_cnt, 32'd0);
        check_eq("z_csf_n",    32'(csf_t.size()), 32'd0);
        check_eq("z_done_n",   32'(done_t.size()), 32'd0);

        // ---- reset mid-SHIFT of word 3 of 10 ----
        sens_idx_mode = 1'b0;
        sens_resp = 16'hC0DE;
        clear_mon();
        pulse_start(6'd10, 16'hFFFF, t0);
        repeat (238) tick();   // cycle t0+239: word 3 SHIFT, SCLK high
        check_eq("r_pre_sclk", 32'(sclk), 32'd1);
        check_eq("r_pre_mosi", 32'(mosi), 32'd1);
        check_eq("r_pre_idx",  32'(word_idx), 32'd3);
        #2 reset = 1'b1;
        #1;
        check_eq("r_csb",  32'(csb), 32'd1);
        check_eq("r_sclk", 32'(sclk), 32'd0);
        check_eq("r_mosi", 32'(mosi), 32'd0);
        check_eq("r_busy", 32'(busy), 32'd0);
        check_eq("r_idx",  32'(word_idx), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (1000) tick();
        check_eq("r_rv_n",   32'(rv_v.size()), 32'd3);
        check_eq("r_done_n", 32'(done_t.size()), 32'd0);
        sens_resp = 16'hBEEF;
        clear_mon();
        pulse_start(6'd1, 16'h0F0F, t0);
        wait_done("r_clean", 200);
        tick();
        tick();
        check_eq("r_clean_rx",   (rv_v.size() > 0) ? 32'(rv_v[0]) : 32'hFFFF_FFFF, 32'hBEEF);
        check_eq("r_clean_mosi", 32'(mosi_cap), 32'h0F0F);
        check_eq("r_clean_done", qt(done_t, 0) - t0, 32'd73);

        // ---- sweep instance: WORD_W=8, SCLK_HALF=1, CS_GAP=1, 3 words ----
        num2   = 6'd3;
        cmd2   = 8'h96;
        start2 = 1'b1;
        t0     = cyc;
        tick();
        start2 = 1'b0;
        check_eq("s_busy_t1", 32'(busy2), 32'd1);
        check_eq("s_csb_t1",  32'(csb2), 32'd0);
        for (int i = 0; i < 200 && !done2; i++) tick();
        tick();
        tick();
        check_eq("s_rv_n",    32'(rv2_v.size()), 32'd3);
        bad = 0;
        for (int i = 0; i < rv2_v.size(); i++) begin
            if (rv2_v[i] != 8'h5A) bad++;
            if (rv2_t[i] - t0 != 32'((i + 1) * P2)) bad++;
        end
        check_eq("s_rv_vals_times", 32'(bad), 32'd0);
        check_eq("s_done_t",  qt(done2_t, 0) - t0, 32'(1 + 3*P2));
        check_eq("s_rises",   rise2_cnt, 32'd24);
        check_eq("s_rise0_t", first_rise2 - t0, 32'd2);
        check_eq("s_mosi",    32'(mosi2_cap), 32'h96);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
